// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/return sequencer: latches an exception, interrupt or mret,
// waits for the pipeline to drain, then commits a one-cycle redirect and CSR update.
module prv_trap_sequencer #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned XLEN        = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [8:0]      exc_flags,
  input  logic            ret,
  input  logic            wfi,
  input  logic            pipe_clear,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] badaddr,
  input  logic [2:0]      irq_pending,
  input  logic            mie_global,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_r,
  output logic            insert_pc,
  output logic [XLEN-1:0] priv_pc,
  output logic            intr,
  output logic            trap_we,
  output logic            mret_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            sleeping
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, SLEEP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      code_q, exc_code, irq_code;
  logic            intr_q, ret_q;
  logic [XLEN-1:0] epc_q, mtval_q, exc_mtval;
  logic            latch_en, latch_intr, latch_ret;
  logic            exc_any, irq_any;

  assign exc_any = |exc_flags;
  assign irq_any = |irq_pending;

  // Bit order of exc_flags is also the cause priority order.
  always_comb begin
    exc_code  = '0;
    exc_mtval = '0;
    if (exc_flags[0]) begin
      exc_code = 4'd1; exc_mtval = badaddr;
    end else if (exc_flags[1]) begin
      exc_code = 4'd2;
    end else if (exc_flags[2]) begin
      exc_code = 4'd0; exc_mtval = badaddr;
    end else if (exc_flags[3]) begin
      exc_code = 4'd11;
    end else if (exc_flags[4]) begin
      exc_code = 4'd3; exc_mtval = epc;
    end else if (exc_flags[5]) begin
      exc_code = 4'd4; exc_mtval = badaddr;
    end else if (exc_flags[6]) begin
      exc_code = 4'd6; exc_mtval = badaddr;
    end else if (exc_flags[7]) begin
      exc_code = 4'd5; exc_mtval = badaddr;
    end else if (exc_flags[8]) begin
      exc_code = 4'd7; exc_mtval = badaddr;
    end
  end

  always_comb begin
    irq_code = 4'd7;
    if (irq_pending[2])      irq_code = 4'd11;
    else if (irq_pending[0]) irq_code = 4'd3;
  end

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    latch_intr = 1'b0;
    latch_ret  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_any) begin
          latch_en = 1'b1;
          state_d  = DRAIN;
        end else if (mie_global && irq_any) begin
          latch_en   = 1'b1;
          latch_intr = 1'b1;
          state_d    = DRAIN;
        end else if (ret) begin
          latch_en  = 1'b1;
          latch_ret = 1'b1;
          state_d   = DRAIN;
        end else if (wfi && !irq_any) begin
          state_d = SLEEP;
        end
      end
      DRAIN:   if (pipe_clear) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      SLEEP:   if (irq_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      code_q  <= '0;
      intr_q  <= 1'b0;
      ret_q   <= 1'b0;
      epc_q   <= '0;
      mtval_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        intr_q  <= latch_intr;
        ret_q   <= latch_ret;
        epc_q   <= epc;
        code_q  <= latch_intr ? irq_code : (latch_ret ? 4'd0 : exc_code);
        mtval_q <= (latch_intr || latch_ret) ? '0 : exc_mtval;
      end
    end
  end

  always_comb begin
    insert_pc = 1'b0;
    priv_pc   = '0;
    intr      = 1'b0;
    trap_we   = 1'b0;
    mret_o    = 1'b0;
    cause_o   = '0;
    mepc_o    = '0;
    mtval_o   = '0;
    sleeping  = (state_q == SLEEP);
    if (state_q == COMMIT) begin
      insert_pc = 1'b1;
      mepc_o    = epc_q;
      if (ret_q) begin
        mret_o  = 1'b1;
        priv_pc = mepc_r;
      end else begin
        trap_we           = 1'b1;
        intr              = intr_q;
        cause_o[XLEN-1]   = intr_q;
        cause_o[3:0]      = code_q;
        mtval_o           = mtval_q;
        priv_pc           = {mtvec[XLEN-1:2], 2'b00};
        if (VECTORED_EN && (mtvec[1:0] == 2'b01) && intr_q)
          priv_pc = priv_pc + XLEN'({1'b0, code_q, 2'b00});
      end
    end
  end

endmodule

// File: doc/prv_trap_sequencer.md
PRV_TRAP_SEQUENCER -- requirements
Module: prv_trap_sequencer

Interface
REQ-001 SHALL have parameter VECTORED_EN, default 1, enabling vectored interrupt targets when mtvec[1:0]==2'b01.
REQ-002 SHALL have parameter XLEN, default 32, the word width of all address/data ports.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 exc_flags  in  9  {fault_s,fault_l,mal_s,mal_l,breakpoint,env,mal_insn,illegal_insn,fault_insn}, bit0=fault_insn, from pipeline hazard unit.
REQ-006 ret  in  1  mret reaching commit; wfi  in  1  wfi reaching commit.
REQ-007 pipe_clear  in  1  pipeline drained, trap/return may be committed.
REQ-008 epc, badaddr  in  XLEN  faulting instruction PC / faulting address.
REQ-009 irq_pending  in  3  {ext,timer,soft} pending AND enabled in mie.
REQ-010 mie_global  in  1  mstatus.MIE; mtvec, mepc_r  in  XLEN  current CSR values.
REQ-011 insert_pc  out  1  redirect fetch to priv_pc; priv_pc  out  XLEN  redirect target; intr  out  1  committed trap is an interrupt.
REQ-012 trap_we  out  1  write mcause/mepc/mtval, mstatus trap update; mret_o  out  1  mstatus return update.
REQ-013 cause_o, mepc_o, mtval_o  out  XLEN  CSR write data; sleeping  out  1  core stalled in wfi.

Function
REQ-014 SHALL implement FSM states IDLE, DRAIN, COMMIT, SLEEP.
REQ-015 IDLE: any exc_flags bit set -> latch exception, go DRAIN; else mie_global && |irq_pending -> latch interrupt, DRAIN; else ret -> latch return, DRAIN; else wfi && !|irq_pending -> SLEEP; else stay.
REQ-016 Priority per cycle SHALL be exception > interrupt > ret > wfi; wfi with pending irq SHALL act as nop.
REQ-017 Exception cause priority (highest first): fault_insn=1, illegal_insn=2, mal_insn=0, env=11, breakpoint=3, mal_l=4, mal_s=6, fault_l=5, fault_s=7.
REQ-018 Interrupt cause priority: ext=11, soft=3, timer=7; cause_o[XLEN-1]=1 for interrupts, 0 for exceptions.
REQ-019 mtval SHALL be badaddr for causes 0,1,4,5,6,7; epc for cause 3; 0 for causes 2,11 and all interrupts.
REQ-020 Latched cause/epc/mtval/kind SHALL be held unchanged through DRAIN and COMMIT; new inputs ignored until return to IDLE.
REQ-021 DRAIN: stay until pipe_clear=1, then COMMIT next edge (DRAIN minimum 1 cycle).
REQ-022 COMMIT: exactly one cycle; insert_pc=1; trap -> trap_we=1, intr per kind; return -> mret_o=1; next state IDLE.
REQ-023 Trap target: {mtvec[XLEN-1:2],2'b00}; if VECTORED_EN && mtvec[1:0]==2'b01 && interrupt, add 4*cause[4:0].
REQ-024 Return target: mepc_r sampled in COMMIT cycle.
REQ-025 mepc_o SHALL equal latched epc; all outputs except sleeping SHALL be 0 outside COMMIT.
REQ-026 SLEEP: sleeping=1; any irq_pending bit -> IDLE regardless of mie_global (resume, then REQ-015 evaluates); exceptions ignored while sleeping.
REQ-027 Latency: event in IDLE with pipe_clear already 1 -> insert_pc asserted 2 cycles later.

Reset
REQ-028 RST=1 SHALL asynchronously force IDLE, clear latched cause/epc/mtval, drive all outputs 0; mid-DRAIN/COMMIT/SLEEP reset abandons the operation with no trap_we or mret_o pulse.

Verification
REQ-029 illegal_insn=1, epc=0x100, mtvec=0x200, pipe_clear=1 -> 2 cycles later one-cycle insert_pc=1, priv_pc=0x200, cause_o=2, mtval_o=0, mepc_o=0x100, trap_we=1.
REQ-030 irq_pending=3'b010 (timer), mie_global=1, mtvec=0x201 -> priv_pc=0x21C, cause_o=0x80000007, intr=1.
REQ-031 fault_l and mal_insn same cycle, badaddr=0x55 -> cause_o=0, mtval_o=0x55; ret same cycle ignored (no mret_o).
REQ-032 ret=1, mepc_r=0x400, pipe_clear held 0 for 5 cycles -> no pulse until pipe_clear=1, then insert_pc=1, priv_pc=0x400, mret_o=1, trap_we=0.
REQ-033 wfi=1, no irq -> sleeping=1; irq_pending=3'b100, mie_global=0 -> sleeping=0 next cycle, no trap.
REQ-034 RST asserted during DRAIN -> outputs 0 immediately, state IDLE, no later pulse after deassertion.
